mux_8_1_scanner: RTL and testbench

- Sequential controller that sits directly upstream of the 8:1 mux. It drives the mux select and samples the mux output.
- On a start request it walks the enabled channels in ascending order. For each channel it drives `sel`, waits a settle time, then samples `mux_out` into a byte-wide capture register.
- When the walk finishes, the assembled byte is presented on a valid/ready output handshake.
- Used to serially read eight single-bit sources through one mux and rebuild them as a parallel word.

---
 rtl/mux_8_1_scanner.sv | 98 +++++++++
 tb/tb_mux_8_1_scanner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_8_1_scanner.sv
`timescale 1ns/1ps
// mux_8_1_scanner: walks the enabled inputs of a downstream 8:1 mux in ascending
// order, samples each after a settle delay, and hands the rebuilt byte out on valid/ready.
module mux_8_1_scanner #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] chan_mask,
  input  logic       mux_out,
  output logic [2:0] sel,
  output logic       busy,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_settle_check
    $fatal(1, "mux_8_1_scanner: SETTLE must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD
  } state_t;

  state_t     state;
  logic [7:0] mask_q;
  logic [3:0] cnt;
  logic [7:0] mask_above;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Enabled channels strictly above the current one; empty means the walk is over.
  assign mask_above = mask_q & (8'hFE << sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= 3'd0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= 8'h00;
      mask_q     <= 8'h00;
      cnt        <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && chan_mask != 8'h00) begin
            mask_q   <= chan_mask;
            data_out <= 8'h00;
            sel      <= lowest_set(chan_mask);
            cnt      <= CNT_INIT;
            busy     <= 1'b1;
            state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == 4'd0) state <= ST_SAMPLE;
          else             cnt   <= cnt - 4'd1;
        end
        ST_SAMPLE: begin
          data_out[sel] <= mux_out;
          if (mask_above != 8'h00) begin
            sel   <= lowest_set(mask_above);
            cnt   <= CNT_INIT;
            state <= ST_SETTLE;
          end else begin
            data_valid <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (data_valid && data_ready) begin
            data_valid <= 1'b0;
            busy       <= 1'b0;
            sel        <= 3'd0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_8_1_scanner.sv
`timescale 1ns/1ps
// tb_mux_8_1_scanner: directed scans against a bench-side 8:1 mux model, with a
// byte scoreboard pushed at each start and popped whenever data_valid is seen.
module tb_mux_8_1_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [7:0] chan_mask;
  logic       data_ready;
  logic [7:0] pattern;
  logic       mux_out;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] data_out;
  logic       data_valid;

  logic       start3;
  logic [7:0] chan_mask3;
  logic       data_ready3;
  logic [7:0] pattern3;
  logic       mux_out3;
  logic [2:0] sel3;
  logic       busy3;
  logic [7:0] data_out3;
  logic       data_valid3;

  assign mux_out  = pattern[sel];
  assign mux_out3 = pattern3[sel3];

  mux_8_1_scanner #(.SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chan_mask(chan_mask),
    .mux_out(mux_out), .sel(sel), .busy(busy), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready)
  );

  mux_8_1_scanner #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .chan_mask(chan_mask3),
    .mux_out(mux_out3), .sel(sel3), .busy(busy3), .data_out(data_out3),
    .data_valid(data_valid3), .data_ready(data_ready3)
  );

  int         check_count = 0;
  int         pass_count  = 0;
  logic [7:0] expq[$];
  logic [2:0] sel_trace[$];
  logic [2:0] sel_trace3[$];
  int         edges;
  int         stable;
  logic [7:0] held;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, output logic [7:0] exp);
    exp = 8'hxx;
    if (expq.size() != 0) exp = expq.pop_front();
    checkOutput(tag, 32'(obs), 32'(exp));
  endtask

  // Reference walk: each enabled channel, ascending, held for settle+1 cycles.
  function automatic int trace_errors(input logic [2:0] trace[$], input logic [7:0] mask,
                                      input int settle);
    int idx;
    int errs;
    idx  = 0;
    errs = 0;
    for (int ch = 0; ch < 8; ch++) begin
      if (mask[ch]) begin
        for (int k = 0; k <= settle; k++) begin
          if (idx >= trace.size()) errs++;
          else if (trace[idx] !== 3'(ch)) errs++;
          idx++;
        end
      end
    end
    if (idx != trace.size()) errs++;
    return errs;
  endfunction

  task automatic applyStimulus(input logic [7:0] mask, input logic [7:0] pat);
    pattern   = pat;
    chan_mask = mask;
    start     = 1'b1;
    expq.push_back(pat & mask);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_valid(input int pulse_at, output int n);
    sel_trace.delete();
    n = 0;
    while (data_valid !== 1'b1 && n < 200) begin
      sel_trace.push_back(sel);
      if (n == pulse_at) begin
        start     = 1'b1;
        chan_mask = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    chan_mask   = 8'h00;
    data_ready  = 1'b1;
    pattern     = 8'h00;
    start3      = 1'b0;
    chan_mask3  = 8'h00;
    data_ready3 = 1'b1;
    pattern3    = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset_sel", 32'(sel), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_valid", 32'(data_valid), 0);
    checkOutput("reset_data", 32'(data_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] full scan");
    applyStimulus(8'hFF, 8'h30);
    checkOutput("full_accept_busy", 32'(busy), 1);
    run_to_valid(-1, edges);
    checkOutput("full_edges", 32'(edges), 16);
    checkOutput("full_sel_seq", 32'(trace_errors(sel_trace, 8'hFF, 1)), 0);
    check_byte("full_data", data_out, held);
    @(negedge clk);
    checkOutput("full_valid_one_cycle", 32'(data_valid), 0);
    checkOutput("full_busy_drop", 32'(busy), 0);
    checkOutput("full_sel_idle", 32'(sel), 0);

    $display("[TB] sparse mask");
    applyStimulus(8'b1000_0101, 8'hFF);
    run_to_valid(-1, edges);
    checkOutput("sparse_edges", 32'(edges), 6);
    checkOutput("sparse_sel_seq", 32'(trace_errors(sel_trace, 8'b1000_0101, 1)), 0);
    check_byte("sparse_data", data_out, held);
    @(negedge clk);

    $display("[TB] backpressure");
    data_ready = 1'b0;
    applyStimulus(8'hFF, 8'h5A);
    run_to_valid(-1, edges);
    checkOutput("bp_edges", 32'(edges), 16);
    check_byte("bp_data", data_out, held);
    stable = 0;
    repeat (5) begin
      @(negedge clk);
      if (data_valid === 1'b1 && data_out === held && sel === 3'd7) stable++;
    end
    checkOutput("bp_stable_cycles", 32'(stable), 5);
    data_ready = 1'b1;
    start      = 1'b1;
    chan_mask  = 8'h01;
    @(negedge clk);
    checkOutput("bp_valid_drop", 32'(data_valid), 0);
    checkOutput("bp_no_accept_on_handshake", 32'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("bp_accept_after_idle", 32'(busy), 1);
    expq.push_back(pattern & 8'h01);
    run_to_valid(-1, edges);
    checkOutput("bp_restart_edges", 32'(edges), 2);
    check_byte("bp_restart_data", data_out, held);
    @(negedge clk);

    $display("[TB] ignored starts");
    applyStimulus(8'hFF, 8'hC3);
    run_to_valid(5, edges);
    checkOutput("ign_edges", 32'(edges), 16);
    checkOutput("ign_sel_seq", 32'(trace_errors(sel_trace, 8'hFF, 1)), 0);
    check_byte("ign_data", data_out, held);
    @(negedge clk);
    chan_mask = 8'h00;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("ign_mask0_busy", 32'(busy), 0);
    checkOutput("ign_mask0_valid", 32'(data_valid), 0);

    $display("[TB] async reset mid-scan");
    applyStimulus(8'hFF, 8'h6F);
    repeat (8) @(negedge clk);
    checkOutput("rst_pre_sel", 32'(sel), 4);
    checkOutput("rst_pre_data", 32'(data_out), 32'h0F);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_sel", 32'(sel), 0);
    checkOutput("rst_async_busy", 32'(busy), 0);
    checkOutput("rst_async_valid", 32'(data_valid), 0);
    checkOutput("rst_async_data", 32'(data_out), 0);
    void'(expq.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'hFF, 8'h9C);
    run_to_valid(-1, edges);
    checkOutput("rst_fresh_edges", 32'(edges), 16);
    check_byte("rst_fresh_data", data_out, held);
    @(negedge clk);

    $display("[TB] SETTLE=3");
    pattern3   = 8'hA5;
    chan_mask3 = 8'h0F;
    start3     = 1'b1;
    expq.push_back(pattern3 & 8'h0F);
    @(negedge clk);
    start3 = 1'b0;
    sel_trace3.delete();
    edges = 0;
    while (data_valid3 !== 1'b1 && edges < 200) begin
      sel_trace3.push_back(sel3);
      if (edges == 6) pattern3 = {~pattern3[7:4], pattern3[3:0]};
      @(negedge clk);
      edges++;
    end
    checkOutput("s3_edges", 32'(edges), 16);
    checkOutput("s3_sel_seq", 32'(trace_errors(sel_trace3, 8'h0F, 3)), 0);
    check_byte("s3_data", data_out3, held);
    @(negedge clk);
    checkOutput("s3_busy_drop", 32'(busy3), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
